// File: rtl/power_gate_sequencer.sv
// Per-domain power-gating sequencer.
// After a programmable idle window, the sequencer runs isolate -> retention save -> switch off.
// On a wake request, it runs switch on -> restore -> de-isolate.
// All outputs are registered. They are decoded from the next state, so they move on the same
// edge as o_pg_state.
// Optional feature macro: PG_PWR_ACK_EN. When it is defined, POWER_UP waits on the i_pwr_ack
// rail-good handshake instead of the fixed settle counter.
module power_gate_sequencer #(
  parameter int unsigned IDLE_THRESH  = 16,
  parameter int unsigned PWRUP_CYCLES = 4,
  parameter int unsigned CNT_W        = 8
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_idle,
  input  logic       i_wake_req,
  input  logic       i_pwr_ack,
  output logic       o_power_gated,
  output logic       o_pwr_sw_en,
  output logic       o_iso_en,
  output logic       o_ret_save,
  output logic       o_ret_restore,
  output logic       o_domain_ready,
  output logic [2:0] o_pg_state
);

  typedef enum logic [2:0] {
    StActive    = 3'd0,
    StIsolate   = 3'd1,
    StSave      = 3'd2,
    StOff       = 3'd3,
    StPowerUp   = 3'd4,
    StRestore   = 3'd5,
    StDeisolate = 3'd6
  } pg_state_e;

  localparam logic [CNT_W-1:0] IdleLast = CNT_W'(IDLE_THRESH - 1);

  pg_state_e        r_state, w_state_d;
  logic [CNT_W-1:0] r_cnt, w_cnt_d;
  logic             w_power_gated_d, w_pwr_sw_en_d, w_iso_en_d;
  logic             w_ret_save_d, w_ret_restore_d, w_domain_ready_d;

`ifndef PG_PWR_ACK_EN
  localparam logic [CNT_W-1:0] PwrupLast = CNT_W'(PWRUP_CYCLES - 1);
  // The rail-good handshake is not used in the fixed-delay build.
  logic w_unused_pwr_ack;
  assign w_unused_pwr_ack = i_pwr_ack;
`endif

  // Next-state, counter and next-output decode
  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = '0;
    case (r_state)
      StActive: begin
        if (i_idle && !i_wake_req) begin
          if (r_cnt == IdleLast) begin
            w_state_d = StIsolate;
          end else begin
            w_cnt_d = r_cnt + 1'b1;
          end
        end
      end
      // A wake arriving during isolation aborts before any state is saved.
      StIsolate: w_state_d = i_wake_req ? StDeisolate : StSave;
      StSave:    w_state_d = StOff;
      StOff: begin
`ifdef PG_PWR_ACK_EN
        // A stale ack from the previous power cycle must drop before power-up starts.
        if (i_wake_req && !i_pwr_ack) w_state_d = StPowerUp;
`else
        if (i_wake_req) w_state_d = StPowerUp;
`endif
      end
      StPowerUp: begin
`ifdef PG_PWR_ACK_EN
        if (i_pwr_ack) w_state_d = StRestore;
`else
        if (r_cnt == PwrupLast) begin
          w_state_d = StRestore;
        end else begin
          w_cnt_d = r_cnt + 1'b1;
        end
`endif
      end
      StRestore:   w_state_d = StDeisolate;
      StDeisolate: w_state_d = StActive;
      default:     w_state_d = StActive;
    endcase

    w_power_gated_d  = (w_state_d == StOff);
    w_pwr_sw_en_d    = (w_state_d != StOff);
    w_iso_en_d       = (w_state_d != StActive);
    w_ret_save_d     = (w_state_d == StSave);
    w_ret_restore_d  = (w_state_d == StRestore);
    w_domain_ready_d = (w_state_d == StActive);
  end

  // State, counter and output registers with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state        <= StActive;
      r_cnt          <= '0;
      o_power_gated  <= 1'b0;
      o_pwr_sw_en    <= 1'b1;
      o_iso_en       <= 1'b0;
      o_ret_save     <= 1'b0;
      o_ret_restore  <= 1'b0;
      o_domain_ready <= 1'b1;
    end else begin
      r_state        <= w_state_d;
      r_cnt          <= w_cnt_d;
      o_power_gated  <= w_power_gated_d;
      o_pwr_sw_en    <= w_pwr_sw_en_d;
      o_iso_en       <= w_iso_en_d;
      o_ret_save     <= w_ret_save_d;
      o_ret_restore  <= w_ret_restore_d;
      o_domain_ready <= w_domain_ready_d;
    end
  end

  assign o_pg_state = r_state;

endmodule

// File: tb/tb_power_gate_sequencer.sv
// Self-checking bench for power_gate_sequencer (IDLE_THRESH=16, PWRUP_CYCLES=4).
// Each cycle, the expected output vector is pushed to a scoreboard queue. The vector is popped
// and compared after the clock edge. Directed checks cover the latency and abort scenarios.
module tb_power_gate_sequencer;

  localparam int IdleThresh  = 16;
  localparam int PwrupCycles = 4;

  logic       clk = 1'b0;
  logic       reset, idle, wake_req, pwr_ack;
  logic       power_gated, pwr_sw_en, iso_en, ret_save, ret_restore, domain_ready;
  logic [2:0] pg_state;

  int n_checks = 0;
  int n_errors = 0;

  logic [8:0] exp_q[$];

  // Reference model state: 0..6 follow the documented encodings.
  int m_state = 0;
  int m_idle_run = 0;
  int m_pu_elapsed = 0;

  power_gate_sequencer #(
    .IDLE_THRESH (IdleThresh),
    .PWRUP_CYCLES(PwrupCycles),
    .CNT_W       (8)
  ) dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_idle        (idle),
    .i_wake_req    (wake_req),
    .i_pwr_ack     (pwr_ack),
    .o_power_gated (power_gated),
    .o_pwr_sw_en   (pwr_sw_en),
    .o_iso_en      (iso_en),
    .o_ret_save    (ret_save),
    .o_ret_restore (ret_restore),
    .o_domain_ready(domain_ready),
    .o_pg_state    (pg_state)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Vector layout: {pg_state, power_gated, pwr_sw_en, iso_en, ret_save, ret_restore, domain_ready}
  function automatic logic [8:0] exp_vec(input int s);
    logic [2:0] enc;
    enc = 3'(s);
    return {enc, s == 3, s != 3, s != 0, s == 2, s == 5, s == 0};
  endfunction

  task automatic model_step(input logic r, input logic id, input logic wk, input logic ak);
    if (r) begin
      m_state = 0; m_idle_run = 0; m_pu_elapsed = 0;
    end else begin
      case (m_state)
        0: begin
          if (id && !wk) begin
            m_idle_run++;
            if (m_idle_run == IdleThresh) begin
              m_state = 1; m_idle_run = 0;
            end
          end else m_idle_run = 0;
        end
        1: m_state = wk ? 6 : 2;
        2: m_state = 3;
        3: begin
`ifdef PG_PWR_ACK_EN
          if (wk && !ak) begin m_state = 4; m_pu_elapsed = 0; end
`else
          if (wk) begin m_state = 4; m_pu_elapsed = 0; end
`endif
        end
        4: begin
`ifdef PG_PWR_ACK_EN
          if (ak) m_state = 5;
`else
          m_pu_elapsed++;
          if (m_pu_elapsed == PwrupCycles) m_state = 5;
`endif
        end
        5: m_state = 6;
        default: m_state = 0;
      endcase
    end
  endtask

  // Drive one cycle, push the expectation, then pop and compare after the edge.
  task automatic step(input logic r, input logic id, input logic wk, input logic ak);
    logic [8:0] obs;
    logic [8:0] exp;
    reset = r; idle = id; wake_req = wk; pwr_ack = ak;
    model_step(r, id, wk, ak);
    exp_q.push_back(exp_vec(m_state));
    @(posedge clk);
    #1;
    obs = {pg_state, power_gated, pwr_sw_en, iso_en, ret_save, ret_restore, domain_ready};
    exp = exp_q.pop_front();
    check_eq("outputs", 32'(obs), 32'(exp));
  endtask

  task automatic go_off();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < IdleThresh + 2; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; idle = 1'b0; wake_req = 1'b0; pwr_ack = 1'b0;
    #2;

    // Reset state
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("reset_state", 32'(pg_state), 32'd0);
    check_eq("reset_sw_en", 32'(pwr_sw_en), 32'd1);
    check_eq("reset_ready", 32'(domain_ready), 32'd1);

    // Continuous idle: isolate at edge 16, save at 17, off from 18
    for (int e = 1; e <= 20; e++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0);
      if (e == 15) check_eq("iso_e15", 32'(iso_en), 32'd0);
      if (e == 16) check_eq("iso_e16", 32'(iso_en), 32'd1);
      if (e == 17) check_eq("save_e17", 32'(ret_save), 32'd1);
      if (e == 18) check_eq("gated_e18", 32'(power_gated), 32'd1);
      if (e == 18) check_eq("sw_off_e18", 32'(pwr_sw_en), 32'd0);
    end

`ifndef PG_PWR_ACK_EN
    // Wake from OFF
    for (int e = 1; e <= 8; e++) begin
      step(1'b0, 1'b0, e <= 7, 1'b0);
      if (e == 1) check_eq("wake_sw_en", 32'(pwr_sw_en), 32'd1);
      if (e == 4) check_eq("wake_no_restore_e4", 32'(ret_restore), 32'd0);
      if (e == 5) check_eq("wake_restore_e5", 32'(ret_restore), 32'd1);
      if (e == 6) check_eq("wake_ready_e6", 32'(domain_ready), 32'd0);
      if (e == 7) check_eq("wake_ready_e7", 32'(domain_ready), 32'd1);
      if (e == 7) check_eq("wake_iso_e7", 32'(iso_en), 32'd0);
    end
`endif

    // Idle broken at edge 11: isolation only at edge 27
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int e = 1; e <= 28; e++) begin
      step(1'b0, e != 11, 1'b0, 1'b0);
      if (e == 16) check_eq("broken_iso_e16", 32'(iso_en), 32'd0);
      if (e == 26) check_eq("broken_iso_e26", 32'(iso_en), 32'd0);
      if (e == 27) check_eq("broken_iso_e27", 32'(pg_state), 32'd1);
    end

    // Wake arriving while in ISOLATE aborts without save
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int e = 1; e <= 19; e++) begin
      step(1'b0, 1'b1, e >= 17, 1'b0);
      if (e >= 16) check_eq("abort_no_save", 32'(ret_save), 32'd0);
      if (e >= 16) check_eq("abort_sw_on", 32'(pwr_sw_en), 32'd1);
      if (e == 17) check_eq("abort_deiso", 32'(pg_state), 32'd6);
      if (e == 18) check_eq("abort_active", 32'(pg_state), 32'd0);
    end

    // Reset during POWER_UP
    go_off();
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("pu_state", 32'(pg_state), 32'd4);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    check_eq("pu_rst_state", 32'(pg_state), 32'd0);
    check_eq("pu_rst_restore", 32'(ret_restore), 32'd0);
    check_eq("pu_rst_iso", 32'(iso_en), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("pu_rst_no_restore", 32'(ret_restore), 32'd0);

`ifdef PG_PWR_ACK_EN
    // Stale ack blocks power-up; then wait on ack in POWER_UP
    go_off();
    step(1'b0, 1'b0, 1'b1, 1'b1);
    check_eq("stale_ack_off", 32'(pg_state), 32'd3);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    for (int e = 1; e <= 10; e++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0);
      check_eq("ack_hold_pu", 32'(pg_state), 32'd4);
    end
    step(1'b0, 1'b0, 1'b1, 1'b1);
    check_eq("ack_restore", 32'(ret_restore), 32'd1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("ack_ready", 32'(domain_ready), 32'd1);
`endif

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 99) == 0, $urandom_range(0, 9) != 0,
           $urandom_range(0, 19) == 0, $urandom_range(0, 3) == 0);
      if (ret_save && ret_restore) check_eq("save_restore_excl", 32'd1, 32'd0);
      if (!pwr_sw_en) check_eq("sw_off_isolated", 32'(iso_en), 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
